// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: TMDS control symbols, lane indices, phase/clock-lane constants
// and the symbol-triple payload carried from the encoder to the serializer.
package hdmi_pkg;

   localparam int unsigned SYM_W    = 10;
   localparam int unsigned PHASES   = 5;
   localparam int unsigned PHASE_W  = 3;
   localparam int unsigned LANES    = 4;
   localparam int unsigned DOUT_W   = 2 * LANES;

   localparam logic [SYM_W-1:0] CTRL00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL11 = 10'b1010101011;

   // TMDS clock lane: five ones then five zeros, transmitted LSB first
   localparam logic [SYM_W-1:0] CK_PATTERN = 10'b0000011111;

   typedef enum logic [1:0] {
      LANE_CK = 2'd0,
      LANE_D0 = 2'd1,
      LANE_D1 = 2'd2,
      LANE_D2 = 2'd3
   } lane_e;

   typedef struct packed {
      logic [SYM_W-1:0] d2;
      logic [SYM_W-1:0] d1;
      logic [SYM_W-1:0] d0;
   } sym_triple_t;

   localparam int unsigned TRIPLE_W = $bits(sym_triple_t);

   // Clock-lane bit pair for a given phase: {second bit, first bit}
   function automatic logic [1:0] ck_pair(input logic [PHASE_W-1:0] phase);
      return CK_PATTERN[{phase, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry valid/ready FIFO for symbol triples. Slot 0 is always the head, so the
// read data comes straight from a register; ready is registered from next occupancy.
module sym_fifo2
   import hdmi_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [TRIPLE_W-1:0] wr_data,
   input  logic                rd_en,
   output logic [TRIPLE_W-1:0] rd_data,
   output logic [1:0]          level
);

   logic [1:0]          level_q;
   logic [1:0]          level_d;
   logic                ready_q;
   logic [TRIPLE_W-1:0] slot0_q;
   logic [TRIPLE_W-1:0] slot1_q;
   logic                do_push;
   logic                do_pop;

   assign do_push = wr_valid & ready_q;
   assign do_pop  = rd_en & (level_q != 2'd0);

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 2'd1;
         2'b01:   level_d = level_q - 2'd1;
         default: level_d = level_q;
      endcase
   end

   // A pop while full cannot coincide with a push because ready was low that cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= 2'd0;
         ready_q <= 1'b1;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         level_q <= level_d;
         ready_q <= (level_d != 2'd2);
         if (do_pop) begin
            if (level_q == 2'd2) begin
               slot0_q <= slot1_q;
            end else if (do_push) begin
               slot0_q <= wr_data;
            end
         end else if (do_push) begin
            if (level_q == 2'd0) begin
               slot0_q <= wr_data;
            end else begin
               slot1_q <= wr_data;
            end
         end
      end
   end

   assign wr_ready = ready_q;
   assign rd_data  = slot0_q;
   assign level    = level_q;

endmodule

// File: rtl/tmds_lane_serializer.sv
// Serializes three TMDS data lanes plus the generated clock lane into an 8-bit DDR word,
// two bits per lane per 5x-pixel clock, with blanking insertion and underflow tracking.
module tmds_lane_serializer
   import hdmi_pkg::*;
#(
   parameter logic [9:0]  BLANK_SYM = CTRL00,
   parameter int unsigned CNT_W     = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic [9:0]       sym_d0,
   input  logic [9:0]       sym_d1,
   input  logic [9:0]       sym_d2,
   output logic             pix_strobe,
   output logic [7:0]       dout,
   output logic             underflow,
   output logic [CNT_W-1:0] uflow_cnt
);

   logic [PHASE_W-1:0]  phase_q;
   logic                load;
   logic                fifo_empty;
   logic                pop;
   logic                starve;
   logic [1:0]          fifo_level;
   logic [TRIPLE_W-1:0] fifo_head;
   sym_triple_t         head;
   sym_triple_t         wr_triple;
   logic [SYM_W-1:0]    sh_d0_q;
   logic [SYM_W-1:0]    sh_d1_q;
   logic [SYM_W-1:0]    sh_d2_q;
   logic [DOUT_W-1:0]   dout_q;
   logic                underflow_q;
   logic [CNT_W-1:0]    cnt_q;

   assign wr_triple = '{d2: sym_d2, d1: sym_d1, d0: sym_d0};

   sym_fifo2 u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_valid (sym_valid),
      .wr_ready (sym_ready),
      .wr_data  (wr_triple),
      .rd_en    (pop),
      .rd_data  (fifo_head),
      .level    (fifo_level)
   );

   assign head       = sym_triple_t'(fifo_head);
   assign load       = (phase_q == PHASE_W'(PHASES - 1));
   assign fifo_empty = (fifo_level == 2'd0);
   assign pop        = load & en & ~fifo_empty;
   assign starve     = load & en & fifo_empty;
   assign pix_strobe = load;

   // Free-running pixel phase, independent of en
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_q <= '0;
      end else if (load) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_q + PHASE_W'(1);
      end
   end

   // Data shifters: load a new symbol on the load cycle, otherwise move two bits along
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_d0_q <= BLANK_SYM;
         sh_d1_q <= BLANK_SYM;
         sh_d2_q <= BLANK_SYM;
      end else if (load) begin
         sh_d0_q <= pop ? head.d0 : BLANK_SYM;
         sh_d1_q <= pop ? head.d1 : BLANK_SYM;
         sh_d2_q <= pop ? head.d2 : BLANK_SYM;
      end else begin
         sh_d0_q <= sh_d0_q >> 2;
         sh_d1_q <= sh_d1_q >> 2;
         sh_d2_q <= sh_d2_q >> 2;
      end
   end

   // Output register: lane k occupies dout[2k+1:2k], first bit in the even position
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= {sh_d2_q[1:0], sh_d1_q[1:0], sh_d0_q[1:0], ck_pair(phase_q)};
      end
   end

   // Sticky underflow flag and saturating count of starved loads
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         underflow_q <= 1'b0;
         cnt_q       <= '0;
      end else if (starve) begin
         underflow_q <= 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign dout      = dout_q;
   assign underflow = underflow_q;
   assign uflow_cnt = cnt_q;

endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Directed-plus-random bench for tmds_lane_serializer; a queue-based pixel model predicts
// every output word, with extra hand-computed checks at the scenario boundaries.
`timescale 1ns/1ps
module tb_tmds_lane_serializer;

   localparam int unsigned CNT_W = 4;
   localparam logic [9:0]  BLANK = 10'b1101010100;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             en = 1'b0;
   logic             sym_valid = 1'b0;
   logic [9:0]       sym_d0 = '0;
   logic [9:0]       sym_d1 = '0;
   logic [9:0]       sym_d2 = '0;
   logic             sym_ready;
   logic             pix_strobe;
   logic [7:0]       dout;
   logic             underflow;
   logic [CNT_W-1:0] uflow_cnt;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tmds_lane_serializer #(.BLANK_SYM(BLANK), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .sym_d0     (sym_d0),
      .sym_d1     (sym_d1),
      .sym_d2     (sym_d2),
      .pix_strobe (pix_strobe),
      .dout       (dout),
      .underflow  (underflow),
      .uflow_cnt  (uflow_cnt)
   );

   // Reference model: pixel phase, queued triples, and the bit pairs still to be sent
   int               m_phase = 0;
   logic [29:0]      m_q[$];
   logic [5:0]       m_pairs[$];
   logic             m_uf = 1'b0;
   logic [CNT_W-1:0] m_cnt = '0;
   logic [7:0]       m_dout = '0;
   logic [1:0]       ck_tab [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
   logic [1:0]       x_d0 [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
   logic [1:0]       x_d1 [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
   logic [1:0]       x_d2 [5] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11};

   function automatic logic [5:0] pair_of(input logic [29:0] t, input int i);
      return {t[20 + 2*i +: 2], t[10 + 2*i +: 2], t[2*i +: 2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_sym();
      sym_d0 = 10'($urandom());
      sym_d1 = 10'($urandom());
      sym_d2 = 10'($urandom());
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare
   task automatic step();
      logic [29:0] sym;
      logic [5:0]  pr;
      int          sz;
      @(posedge clk);
      if (!reset_n) begin
         m_phase = 0;
         m_q.delete();
         m_pairs.delete();
         for (int i = 0; i < 5; i++) m_pairs.push_back(pair_of({BLANK, BLANK, BLANK}, i));
         m_uf   = 1'b0;
         m_cnt  = '0;
         m_dout = '0;
      end else begin
         sz  = m_q.size();
         sym = {BLANK, BLANK, BLANK};
         if (m_phase == 4) begin
            if (en && sz > 0) sym = m_q.pop_front();
            if (en && sz == 0) begin
               m_uf = 1'b1;
               if (m_cnt != CNT_MAX) m_cnt = m_cnt + CNT_W'(1);
            end
         end
         if (sym_valid && sz < 2) m_q.push_back({sym_d2, sym_d1, sym_d0});
         pr = m_pairs.pop_front();
         m_dout = {pr, ck_tab[m_phase]};
         if (m_phase == 4) begin
            for (int i = 0; i < 5; i++) m_pairs.push_back(pair_of(sym, i));
         end
         m_phase = (m_phase + 1) % 5;
      end
      @(negedge clk);
      check("dout", 32'(dout), 32'(m_dout));
      check("sym_ready", 32'(sym_ready), 32'(m_q.size() < 2));
      check("pix_strobe", 32'(pix_strobe), 32'(m_phase == 4));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("uflow_cnt", 32'(uflow_cnt), 32'(m_cnt));
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 6 && m_phase != p; i++) step();
   endtask

   task automatic fill_fifo();
      logic acc;
      sym_valid = 1'b1;
      randomize_sym();
      for (int i = 0; i < 8 && sym_ready; i++) begin
         acc = sym_ready;
         step();
         if (acc) randomize_sym();
      end
      sym_valid = 1'b0;
   endtask

   initial begin
      logic acc;

      // Reset held for three clocks
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_ready", 32'(sym_ready), 32'h1);
      check("rst_cnt", 32'(uflow_cnt), 32'h0);
      check("rst_uf", 32'(underflow), 32'h0);
      check("rst_strobe", 32'(pix_strobe), 32'h0);
      reset_n = 1'b1;

      // Idle with en=0: clock pattern and blanking only
      for (int i = 0; i < 10; i++) step();
      check("idle_uf", 32'(underflow), 32'h0);

      // Single known symbol pushed ahead of a load cycle
      wait_phase(1);
      en = 1'b1;
      sym_valid = 1'b1;
      sym_d0 = 10'h2AA;
      sym_d1 = 10'h155;
      sym_d2 = 10'h3F0;
      step();
      sym_valid = 1'b0;
      wait_phase(4);
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         check("ss_d0", 32'(dout[3:2]), 32'(x_d0[k]));
         check("ss_d1", 32'(dout[5:4]), 32'(x_d1[k]));
         check("ss_d2", 32'(dout[7:6]), 32'(x_d2[k]));
      end

      // Underflow: three starved loads, then saturation
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("uf_flag", 32'(underflow), 32'h1);
      check("uf_cnt3", 32'(uflow_cnt), 32'h3);
      check("uf_blank_d0", 32'(dout[3:2]), 32'(BLANK[9:8]));
      for (int i = 0; i < 100; i++) step();
      check("uf_sat", 32'(uflow_cnt), 32'(CNT_MAX));

      // Back-pressure: valid held high for 100 pixels of random symbols
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      en = 1'b1;
      sym_valid = 1'b1;
      randomize_sym();
      step();
      randomize_sym();
      step();
      randomize_sym();
      check("bp_ready_low", 32'(sym_ready), 32'h0);
      for (int i = 0; i < 500; i++) begin
         acc = sym_ready;
         step();
         if (acc) randomize_sym();
      end
      check("bp_no_uf", 32'(underflow), 32'h0);

      // en=0 with a full FIFO: blanking, no pops, no counting; then drain in order
      for (int i = 0; i < 6 && sym_ready; i++) step();
      sym_valid = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("dis_full", 32'(sym_ready), 32'h0);
      check("dis_cnt", 32'(uflow_cnt), 32'h0);
      en = 1'b1;
      for (int i = 0; i < 12; i++) step();

      // Reset at phase 2 with a full FIFO discards everything
      fill_fifo();
      check("mid_full", 32'(sym_ready), 32'h0);
      wait_phase(2);
      reset_n = 1'b0;
      step();
      check("mid_dout", 32'(dout), 32'h00);
      check("mid_ready", 32'(sym_ready), 32'h1);
      check("mid_strobe", 32'(pix_strobe), 32'h0);
      reset_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("mid_empty_uf", 32'(underflow), 32'h1);
      check("mid_empty_cnt", 32'(uflow_cnt), 32'h1);
      for (int i = 0; i < 5; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
